riscv_boot_loader: RTL and testbench

Byte-stream boot controller placed in front of `riscv_cpu_core`. It receives a framed program image over a valid/ready byte interface, typically from a UART receiver. It assembles little-endian words and drives the core's `prog_en`/`prog_addr`/`prog_data` instruction-memory write port. After the image's checksum verifies, it releases the core by asserting `core_start`, which connects to the core's `start` input.

---
 rtl/riscv_boot_loader.sv | 126 ++++++++++++
 tb/tb_riscv_boot_loader.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_boot_loader.sv
// rtl/riscv_boot_loader.sv - framed byte-stream image loader driving the core's instruction-memory write port
module riscv_boot_loader #(
  parameter logic [31:0] MAGIC     = 32'h4C42_5652,
  parameter int unsigned MAX_WORDS = 4096,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  input  logic        reload,
  output logic        prog_en,
  output logic [31:0] prog_addr,
  output logic [31:0] prog_data,
  output logic        core_start,
  output logic        error,
  output logic [15:0] words_loaded
);

  typedef enum logic [2:0] {HUNT, LEN, LOAD, CSUM, RUN, ERR} state_t;

  state_t      state, state_n;
  logic [1:0]  idx, idx_n;
  logic [31:0] shreg, shreg_n;
  logic [31:0] csum, csum_n;
  logic [15:0] len, len_n;
  logic [15:0] count_n;
  logic        prog_en_n;
  logic [31:0] prog_addr_n, prog_data_n;
  logic        fire;
  logic [31:0] word;
  logic [7:0]  magic_byte;

  assign fire       = rx_valid & rx_ready;
  // Bytes arrive LSB first, so each one enters at the top and shifts down.
  assign word       = {rx_data, shreg[31:8]};
  assign magic_byte = MAGIC[{idx, 3'b000} +: 8];

  assign rx_ready   = ~reset & ((state == HUNT) | (state == LEN) |
                                (state == LOAD) | (state == CSUM));
  assign core_start = (state == RUN);
  assign error      = (state == ERR);

  always_comb begin
    state_n     = state;
    idx_n       = idx;
    shreg_n     = shreg;
    csum_n      = csum;
    len_n       = len;
    count_n     = words_loaded;
    prog_en_n   = 1'b0;
    prog_addr_n = prog_addr;
    prog_data_n = prog_data;
    if (reload) begin
      state_n = HUNT;
      idx_n   = 2'd0;
      shreg_n = 32'd0;
      csum_n  = 32'd0;
      count_n = 16'd0;
    end else if (fire) begin
      shreg_n = word;
      idx_n   = idx + 2'd1;
      case (state)
        HUNT: begin
          if (rx_data == magic_byte) begin
            if (idx == 2'd3) state_n = LEN;
          end else begin
            idx_n = (rx_data == MAGIC[7:0]) ? 2'd1 : 2'd0;
          end
        end
        LEN: begin
          if (idx == 2'd3) begin
            if (word == 32'd0 || word > 32'(MAX_WORDS)) begin
              state_n = ERR;
            end else begin
              state_n = LOAD;
              len_n   = word[15:0];
              count_n = 16'd0;
              csum_n  = 32'd0;
            end
          end
        end
        LOAD: begin
          if (idx == 2'd3) begin
            prog_en_n   = 1'b1;
            prog_addr_n = BASE_ADDR + {14'd0, words_loaded, 2'b00};
            prog_data_n = word;
            csum_n      = csum + word;
            count_n     = words_loaded + 16'd1;
            if (words_loaded + 16'd1 == len) state_n = CSUM;
          end
        end
        CSUM: begin
          if (idx == 2'd3) state_n = (word == csum) ? RUN : ERR;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= HUNT;
      idx          <= 2'd0;
      shreg        <= 32'd0;
      csum         <= 32'd0;
      len          <= 16'd0;
      words_loaded <= 16'd0;
      prog_en      <= 1'b0;
      prog_addr    <= BASE_ADDR;
      prog_data    <= 32'd0;
    end else begin
      state        <= state_n;
      idx          <= idx_n;
      shreg        <= shreg_n;
      csum         <= csum_n;
      len          <= len_n;
      words_loaded <= count_n;
      prog_en      <= prog_en_n;
      prog_addr    <= prog_addr_n;
      prog_data    <= prog_data_n;
    end
  end

endmodule

// File: tb/tb_riscv_boot_loader.sv
// tb/tb_riscv_boot_loader.sv - directed self-checking bench for riscv_boot_loader
module tb_riscv_boot_loader;

  localparam logic [31:0] MAGIC = 32'h4C42_5652;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'd0;
  logic        reload = 1'b0;
  logic        rx_ready;
  logic        prog_en;
  logic [31:0] prog_addr;
  logic [31:0] prog_data;
  logic        core_start;
  logic        error;
  logic [15:0] words_loaded;

  int tests_run = 0;
  int tests_failed = 0;

  logic [31:0] wr_addr[$];
  logic [31:0] wr_data[$];
  logic [31:0] img[0:15];

  riscv_boot_loader dut (
    .clk(clk), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data),
    .rx_ready(rx_ready), .reload(reload), .prog_en(prog_en),
    .prog_addr(prog_addr), .prog_data(prog_data), .core_start(core_start),
    .error(error), .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (prog_en === 1'b1) begin
      wr_addr.push_back(prog_addr);
      wr_data.push_back(prog_data);
    end
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    int wait_cnt;
    repeat (gap) @(negedge clk);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    wait_cnt = 0;
    while (rx_ready !== 1'b1 && wait_cnt < 50) begin
      @(negedge clk);
      wait_cnt++;
    end
    if (rx_ready !== 1'b1) begin
      tests_run++;
      tests_failed++;
      $display("FAIL rx_ready_timeout: rx_ready=%b, required 1", rx_ready);
    end
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input int gap_max);
    for (int i = 0; i < 4; i++)
      send_byte(w[8*i +: 8], (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0);
  endtask

  task automatic do_reload();
    @(negedge clk);
    reload = 1'b1;
    @(posedge clk);
    #1;
    reload = 1'b0;
  endtask

  task automatic clear_log();
    wr_addr.delete();
    wr_data.delete();
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    tests_run++;
    if (rx_ready !== 1'b0) begin tests_failed++; $display("FAIL reset_rx_ready_held: got %b, required 0", rx_ready); end
    reset = 1'b0;
    #1;
    tests_run++;
    if (rx_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_rx_ready: got %b, required 1", rx_ready); end
    tests_run++;
    if ({prog_en, core_start, error} !== 3'b000) begin tests_failed++; $display("FAIL reset_flags: got %b, required 000", {prog_en, core_start, error}); end
    tests_run++;
    if (prog_addr !== 32'h0 || prog_data !== 32'h0) begin tests_failed++; $display("FAIL reset_prog_bus: got %h/%h, required 0/0", prog_addr, prog_data); end
    tests_run++;
    if (words_loaded !== 16'd0) begin tests_failed++; $display("FAIL reset_words: got %0d, required 0", words_loaded); end
  endtask

  task automatic test_good_image();
    logic [31:0] exp_d[3];
    logic [31:0] cs;
    exp_d = '{32'h0000_0013, 32'h0010_0093, 32'hFFFF_FFFF};
    cs = 32'h0010_00A5;
    clear_log();
    send_word(MAGIC, 0);
    send_word(32'd3, 0);
    for (int i = 0; i < 3; i++) send_word(exp_d[i], 0);
    for (int i = 0; i < 3; i++) send_byte(cs[8*i +: 8], 0);
    tests_run++;
    if (core_start !== 1'b0) begin tests_failed++; $display("FAIL good_start_early: got %b, required 0", core_start); end
    send_byte(cs[31:24], 0);
    tests_run++;
    if (core_start !== 1'b1 || rx_ready !== 1'b0) begin tests_failed++; $display("FAIL good_start: core_start=%b rx_ready=%b, required 1/0", core_start, rx_ready); end
    tests_run++;
    if (wr_addr.size() != 3) begin tests_failed++; $display("FAIL good_write_count: got %0d, required 3", wr_addr.size()); end
    for (int i = 0; i < 3 && i < wr_addr.size(); i++) begin
      tests_run++;
      if (wr_addr[i] !== 32'(4*i) || wr_data[i] !== exp_d[i]) begin
        tests_failed++;
        $display("FAIL good_write%0d: got %h/%h, required %h/%h", i, wr_addr[i], wr_data[i], 32'(4*i), exp_d[i]);
      end
    end
    tests_run++;
    if (words_loaded !== 16'd3) begin tests_failed++; $display("FAIL good_words: got %0d, required 3", words_loaded); end
    // RUN must ignore further traffic.
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = 8'h52;
    repeat (4) @(negedge clk);
    rx_valid = 1'b0;
    tests_run++;
    if (core_start !== 1'b1 || words_loaded !== 16'd3) begin tests_failed++; $display("FAIL run_ignores_rx: core_start=%b words=%0d, required 1/3", core_start, words_loaded); end
  endtask

  task automatic test_bad_checksum();
    clear_log();
    do_reload();
    send_word(MAGIC, 0);
    send_word(32'd3, 0);
    send_word(32'h0000_0013, 0);
    send_word(32'h0010_0093, 0);
    send_word(32'hFFFF_FFFF, 0);
    send_word(32'h0010_00A4, 0);
    tests_run++;
    if (error !== 1'b1 || core_start !== 1'b0 || rx_ready !== 1'b0) begin tests_failed++; $display("FAIL bad_csum_err: error=%b core_start=%b rx_ready=%b, required 1/0/0", error, core_start, rx_ready); end
    tests_run++;
    if (wr_addr.size() != 3) begin tests_failed++; $display("FAIL bad_csum_writes: got %0d, required 3", wr_addr.size()); end
    repeat (3) @(negedge clk);
    tests_run++;
    if (error !== 1'b1 || core_start !== 1'b0) begin tests_failed++; $display("FAIL bad_csum_hold: error=%b core_start=%b, required 1/0", error, core_start); end
    do_reload();
    tests_run++;
    if (error !== 1'b0 || rx_ready !== 1'b1 || words_loaded !== 16'd0) begin tests_failed++; $display("FAIL bad_csum_reload: error=%b rx_ready=%b words=%0d, required 0/1/0", error, rx_ready, words_loaded); end
  endtask

  task automatic test_resync();
    logic [7:0] pre[5];
    pre = '{8'h52, 8'h52, 8'h56, 8'h42, 8'h4C};
    clear_log();
    // The trailing four preamble bytes complete the sync word after a false start.
    for (int i = 0; i < 5; i++) send_byte(pre[i], 0);
    send_word(32'd2, 0);
    send_word(32'hDEAD_BEEF, 0);
    send_word(32'h1234_5678, 0);
    send_word(32'hF0E2_1567, 0);
    tests_run++;
    if (core_start !== 1'b1 || error !== 1'b0) begin tests_failed++; $display("FAIL resync_start: core_start=%b error=%b, required 1/0", core_start, error); end
    tests_run++;
    if (wr_addr.size() != 2) begin
      tests_failed++; $display("FAIL resync_writes: got %0d, required 2", wr_addr.size());
    end else if (wr_addr[0] !== 32'h0 || wr_data[0] !== 32'hDEAD_BEEF || wr_addr[1] !== 32'h4 || wr_data[1] !== 32'h1234_5678) begin
      tests_failed++; $display("FAIL resync_writes: got %h/%h %h/%h, required 0/deadbeef 4/12345678", wr_addr[0], wr_data[0], wr_addr[1], wr_data[1]);
    end
    do_reload();
  endtask

  task automatic test_length_limits();
    logic [31:0] lens[2];
    lens = '{32'd0, 32'd4097};
    clear_log();
    for (int k = 0; k < 2; k++) begin
      send_word(MAGIC, 0);
      send_word(lens[k], 0);
      tests_run++;
      if (error !== 1'b1 || rx_ready !== 1'b0) begin tests_failed++; $display("FAIL len_limit_%0d: error=%b rx_ready=%b, required 1/0", lens[k], error, rx_ready); end
      do_reload();
    end
    send_word(MAGIC, 0);
    send_word(32'd4096, 0);
    tests_run++;
    if (error !== 1'b0 || rx_ready !== 1'b1) begin tests_failed++; $display("FAIL len_max_accepted: error=%b rx_ready=%b, required 0/1", error, rx_ready); end
    do_reload();
    tests_run++;
    if (wr_addr.size() != 0) begin tests_failed++; $display("FAIL len_no_writes: got %0d, required 0", wr_addr.size()); end
  endtask

  task automatic test_stalls();
    logic [31:0] cs;
    cs = 32'd0;
    for (int i = 0; i < 16; i++) begin
      img[i] = 32'h9E37_79B9 * 32'(i + 1);
      cs = cs + img[i];
    end
    for (int pass = 0; pass < 2; pass++) begin
      clear_log();
      send_word(MAGIC, pass * 3);
      send_word(32'd16, pass * 3);
      for (int i = 0; i < 16; i++) send_word(img[i], pass * 3);
      send_word(cs, pass * 3);
      tests_run++;
      if (core_start !== 1'b1 || words_loaded !== 16'd16) begin tests_failed++; $display("FAIL stall%0d_start: core_start=%b words=%0d, required 1/16", pass, core_start, words_loaded); end
      tests_run++;
      if (wr_addr.size() != 16) begin
        tests_failed++; $display("FAIL stall%0d_count: got %0d, required 16", pass, wr_addr.size());
      end else begin
        for (int i = 0; i < 16; i++) begin
          if (wr_addr[i] !== 32'(4*i) || wr_data[i] !== img[i]) begin
            tests_failed++;
            $display("FAIL stall%0d_write%0d: got %h/%h, required %h/%h", pass, i, wr_addr[i], wr_data[i], 32'(4*i), img[i]);
            break;
          end
        end
      end
      do_reload();
    end
  endtask

  task automatic test_reload_midword();
    clear_log();
    send_word(MAGIC, 0);
    send_word(32'd16, 0);
    for (int i = 0; i < 5; i++) send_word(img[i], 0);
    send_byte(img[5][7:0], 0);
    send_byte(img[5][15:8], 0);
    do_reload();
    repeat (4) @(negedge clk);
    tests_run++;
    if (wr_addr.size() != 5) begin tests_failed++; $display("FAIL reload_partial_writes: got %0d, required 5", wr_addr.size()); end
    tests_run++;
    if (words_loaded !== 16'd0 || rx_ready !== 1'b1 || error !== 1'b0) begin tests_failed++; $display("FAIL reload_state: words=%0d rx_ready=%b error=%b, required 0/1/0", words_loaded, rx_ready, error); end
    clear_log();
    send_word(MAGIC, 0);
    send_word(32'd3, 0);
    send_word(32'h0000_0013, 0);
    send_word(32'h0010_0093, 0);
    send_word(32'hFFFF_FFFF, 0);
    send_word(32'h0010_00A5, 0);
    tests_run++;
    if (core_start !== 1'b1 || wr_addr.size() != 3) begin tests_failed++; $display("FAIL reload_then_load: core_start=%b writes=%0d, required 1/3", core_start, wr_addr.size()); end
  endtask

  task automatic test_reset_running();
    tests_run++;
    if (core_start !== 1'b1) begin tests_failed++; $display("FAIL reset_run_pre: core_start=%b, required 1", core_start); end
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    tests_run++;
    if (core_start !== 1'b0 || rx_ready !== 1'b0) begin tests_failed++; $display("FAIL reset_async: core_start=%b rx_ready=%b, required 0/0", core_start, rx_ready); end
    @(negedge clk);
    reset = 1'b0;
    #1;
    tests_run++;
    if (prog_addr !== 32'h0 || rx_ready !== 1'b1 || words_loaded !== 16'd0 || core_start !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_release: prog_addr=%h rx_ready=%b words=%0d core_start=%b, required 0/1/0/0", prog_addr, rx_ready, words_loaded, core_start);
    end
  endtask

  initial begin
    test_reset();
    test_good_image();
    test_bad_checksum();
    test_resync();
    test_length_limits();
    test_stalls();
    test_reload_midword();
    test_reset_running();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
